// File: rtl/ovl_fire_event_logger.sv
// ovl_fire_event_logger
// Synchronizes a 3-bit asynchronous fire vector, detects rising edges,
// keeps per-bit saturating occurrence counters and queues timestamped
// {mask, time} records in a small FIFO drained by a valid/ready consumer.
module ovl_fire_event_logger #(
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int TS_WIDTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [2:0]           fire_in,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2:0]           evt_mask,
  output logic [TS_WIDTH-1:0]  evt_time,
  output logic [CNT_WIDTH-1:0] count_2state,
  output logic [CNT_WIDTH-1:0] count_xcheck,
  output logic [CNT_WIDTH-1:0] count_cover,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 3 + TS_WIDTH;

  logic [2:0]           sync_q [SYNC_STAGES];
  logic [2:0]           prev_q;
  logic [TS_WIDTH-1:0]  ts_q;
  logic [RW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        wptr_q;
  logic [PW-1:0]        rptr_q;
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];
  logic                 overflow_q;
  logic                 overflow_d;

  logic [2:0] sync_s;
  logic [2:0] rise_s;
  logic       event_s;
  logic       empty_s;
  logic       full_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign rise_s  = sync_s & ~prev_q & {3{enable}};
  assign event_s = (rise_s != 3'b000);

  // Full when the wrap bits differ but the index bits match.
  assign empty_s = (wptr_q == rptr_q);
  assign full_s  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_s   = !empty_s && evt_ready;
  assign push_s  = event_s && (!full_s || pop_s);
  assign drop_s  = event_s && full_s && !pop_s;

  // Synchronizer chain and previous-sample register (prev ignores enable).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
      prev_q <= 3'b000;
    end else begin
      sync_q[0] <= fire_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_s;
    end
  end

  // Free-running timestamp, wraps naturally at its width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // FIFO storage and pointers; a record carries the pre-edge timestamp.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wptr_q[AW-1:0]] <= {rise_s, ts_q};
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  // Counter and overflow next state: clear beats increment, a drop beats clear.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      cnt_d[b] = cnt_q[b];
      if (clear) begin
        cnt_d[b] = '0;
      end else if (rise_s[b] && (cnt_q[b] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[b] = cnt_q[b] + CNT_WIDTH'(1);
      end else begin
        cnt_d[b] = cnt_q[b];
      end
    end
    overflow_d = overflow_q;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid              = !empty_s;
  assign {evt_mask, evt_time}   = mem_q[rptr_q[AW-1:0]];
  assign count_2state           = cnt_q[0];
  assign count_xcheck           = cnt_q[1];
  assign count_cover            = cnt_q[2];
  assign overflow               = overflow_q;

endmodule

// File: doc/ovl_fire_event_logger.md
# ovl_fire_event_logger

Clocked collector that sits directly downstream of the unclocked never-unknown-async checker and consumes its fire vector. It synchronizes the three fire bits into the checker-bench clock domain and detects their rising edges. For each bit it keeps a saturating occurrence counter. It queues timestamped event records in a small FIFO, which a bench-side reporter drains through a valid/ready handshake.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_WIDTH, 8: width of each occurrence counter.
- TS_WIDTH, 16: width of the free-running timestamp.
- SYNC_STAGES, 2: synchronizer flops per fire bit; ≥2.

- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  synchronous; 0 suppresses event detection.
- clear  input  1  synchronous pulse; zeroes the counters and `overflow`.
- fire_in  input  3  asynchronous fire vector: bit0 = 2-state, bit1 = X/Z check, bit2 = cover.
- evt_valid  output  1  FIFO head is valid.
- evt_ready  input  1  consumer accepts the head.
- evt_mask  output  3  rising-edge mask of the head record.
- evt_time  output  TS_WIDTH  timestamp of the head record.
- count_2state  output  CNT_WIDTH  bit0 rising-edge count.
- count_xcheck  output  CNT_WIDTH  bit1 rising-edge count.
- count_cover  output  CNT_WIDTH  bit2 rising-edge count.
- overflow  output  1  sticky; a record was dropped because the FIFO was full.

## Operation
- **Synchronizer.** Each fire_in bit passes through SYNC_STAGES flops, giving `s`. A `prev` register holds `s` from the last edge and updates every cycle, regardless of enable.
- **Edge detect.** `rise = s & ~prev & {3{enable}}`. An event occurs when `rise != 0`.
- Re-enabling while a bit is held high generates no event. The bit must fall and rise again.
- **Timestamp.** `ts` increments every cycle and wraps from 2^TS_WIDTH−1 to 0.
- A record stores the `ts` value present before the write edge.
- **FIFO.** Each entry is {mask, time}. At most one push per cycle, so simultaneous rises on several bits produce one record with a multi-bit mask.
- Push occurs on an event when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- **Overflow.** Push while full with no pop drops the record and sets `overflow`. Counters still increment.
- **Pop.** Pop occurs when evt_valid && evt_ready.
- Push and pop on a non-empty FIFO in the same cycle keep occupancy unchanged.
- A push into an empty FIFO is not bypassed. The record appears on the next cycle.
- **Handshake.** evt_mask and evt_time are stable while evt_valid && !evt_ready. evt_ready while !evt_valid has no effect.
- Read and write pointers are log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH. Full and empty are decided by comparing the MSB and index bits.
- **Counters.** A counter increments when its `rise` bit is 1 and saturates at 2^CNT_WIDTH−1.
- clear wins over an increment in the same cycle: the counter becomes 0.
- clear also zeroes `overflow`. If clear and a drop coincide, `overflow` becomes 1.
- clear does not affect the FIFO or `ts`.

## Timing
- **Reset values.** Asserting reset immediately forces:
  - evt_valid = 0, evt_mask = 0, evt_time = 0;
  - all counters = 0, overflow = 0;
  - FIFO empty, `ts` = 0;
  - synchronizer and `prev` = 0.
- A fire_in bit held high at reset release is seen as a rising edge once it propagates through the synchronizer.
- **Reset mid-operation.** Queued records are discarded without any handshake.
- **Latency.** fire_in is first sampled high at edge N.
  - `s` goes high after edge N+SYNC_STAGES−1.
  - The push and counter increment happen at edge N+SYNC_STAGES.
  - evt_valid rises after that edge. With defaults, that is 3 edges from first sample to evt_valid.
- **Throughput.** One record per cycle in and one out. A pulse on fire_in narrower than one clock period may be missed; this is permitted.

## Test plan
- **Single event.** Reset, enable=1, evt_ready=0; raise fire_in=3'b010 just before edge 10.
  - evt_valid rises after edge 12 with evt_mask=3'b010 and evt_time=12 (ts counts from 0 after reset release).
  - count_xcheck=1. The record holds while evt_ready=0, then pops on evt_ready=1.
- **Simultaneous rises and enable gating.** Raise fire_in 3'b000→3'b101 → one record, mask 3'b101; count_2state=1 and count_cover=1.
  - Then enable=0: toggle bit0 twice → no records, counts unchanged.
  - Hold bit0 high, enable=1 → no record.
- **Overflow.** evt_ready=0; produce 5 separate bit0 pulses with DEPTH=4.
  - Result: 4 records queued, overflow=1, count_2state=5.
  - Drain all four: masks 3'b001, times strictly increasing.
  - Then pulse clear → overflow=0, counts=0, FIFO contents unaffected.
- **Full with push and pop together.** With the FIFO full, assert evt_ready and a new event in the same cycle → no drop, overflow stays 0, occupancy stays 4.
- **Saturation and clear priority.** With CNT_WIDTH=2, 5 bit2 pulses → count_cover=3.
  - clear coincident with a rise → count_cover=0.
- **Asynchronous reset.** Assert reset mid-drain with 3 records queued and not on a clock edge → evt_valid=0 and counters=0 immediately.
